str_unpack: RTL

- Width-down stream adapter. Accepts wide words that carry a sub-word count and emits them as a narrow stream, LSB sub-word first.
- Marks the final valid sub-word with dn_last when the wide word carried up_last.
- Complements the gear-box deserializer: a partial, last-forced wide word can be restored to exactly the narrow words that built it.
- Sits at the boundary between wide buffer or DMA paths and narrow compute streams.

---
 rtl/str_unpack_pkg.sv | 32 +++
 rtl/str_unpack_if.sv | 34 +++
 rtl/str_unpack_skid.sv | 54 +++++
 rtl/str_unpack.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/str_unpack_pkg.sv
// Shared definitions for the wide/narrow stream adapters (unpacker and the
// gear-box deserializer on the other side).
//   str_clog2      : ceil(log2(value)), constant-foldable
//   str_cnt_width  : width of a sub-word count able to hold 0..nb
//   STR_CNT_FULL   : count encoding that stands for a completely full word
//   ser_state_e    : serializer state encoding
package str_unpack_pkg;

  function automatic int str_clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return w;
  endfunction

  function automatic int str_cnt_width(input int nb);
    return (str_clog2(nb + 1) < 1) ? 1 : str_clog2(nb + 1);
  endfunction

  localparam int STR_CNT_FULL = 0;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } ser_state_e;

endpackage

// File: rtl/str_unpack_if.sv
// Bus bundle for str_unpack: wide up-stream side (data/cnt/last/val/rdy)
// and narrow down-stream side (data/last/val/rdy).
//   master : the environment (drives up words, consumes dn words)
//   slave  : the adapter itself
interface str_unpack_if
  import str_unpack_pkg::*;
#(
  parameter int DATA_UP_WIDTH = 8,
  parameter int DATA_DN_WIDTH = 2
);
  localparam int DATA_NB   = DATA_UP_WIDTH / DATA_DN_WIDTH;
  localparam int CNT_WIDTH = str_cnt_width(DATA_NB);

  logic [DATA_UP_WIDTH-1:0] up_data;
  logic [CNT_WIDTH-1:0]     up_cnt;
  logic                     up_last;
  logic                     up_val;
  logic                     up_rdy;
  logic [DATA_DN_WIDTH-1:0] dn_data;
  logic                     dn_last;
  logic                     dn_val;
  logic                     dn_rdy;

  modport master (
    output up_data, up_cnt, up_last, up_val, dn_rdy,
    input  up_rdy, dn_data, dn_last, dn_val
  );

  modport slave (
    input  up_data, up_cnt, up_last, up_val, dn_rdy,
    output up_rdy, dn_data, dn_last, dn_val
  );

endinterface

// File: rtl/str_unpack_skid.sv
// str_skid: one-entry skid buffer with a registered in_rdy.
//   in_data/in_val/in_rdy    : upstream side, in_rdy comes straight from a flop
//   out_data/out_val/out_rdy : downstream side, pass-through when the skid is empty
// A word arriving while out_rdy is low is parked in the skid entry; in_rdy
// then drops on the next edge, so at most one word is absorbed per stall.
module str_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_val,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_val,
  input  logic             out_rdy
);
  logic             skid_val_q, skid_val_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_rdy_q, in_rdy_d;
  logic             in_fire;

  always_comb begin
    in_fire     = in_val & in_rdy_q;
    out_val     = skid_val_q | in_fire;
    out_data    = skid_val_q ? skid_data_q : in_data;
    skid_val_d  = skid_val_q;
    skid_data_d = skid_data_q;
    if (skid_val_q) begin
      if (out_rdy) skid_val_d = 1'b0;
    end else if (in_fire && !out_rdy) begin
      skid_val_d  = 1'b1;
      skid_data_d = in_data;
    end
    in_rdy_d = ~skid_val_d;
  end

  assign in_rdy = in_rdy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_val_q <= 1'b0;
      in_rdy_q   <= 1'b0;
    end else begin
      skid_val_q <= skid_val_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

endmodule

// File: rtl/str_unpack.sv
// str_unpack: width-down stream adapter. Each accepted wide word is emitted
// as cnt_eff narrow words, LSB sub-word first; the final one carries dn_last
// when the wide word carried up_last.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : str_unpack_if.slave (up_* wide side, dn_* narrow side)
// Pipeline: skid (registered up_rdy) -> holding register -> output register.
module str_unpack
  import str_unpack_pkg::*;
#(
  parameter int DATA_UP_WIDTH = 8,
  parameter int DATA_DN_WIDTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  str_unpack_if.slave  bus
);
  localparam int DATA_NB   = DATA_UP_WIDTH / DATA_DN_WIDTH;
  localparam int CNT_WIDTH = str_cnt_width(DATA_NB);
  localparam int SKID_W    = DATA_UP_WIDTH + CNT_WIDTH + 1;

  if ((DATA_UP_WIDTH % DATA_DN_WIDTH) != 0 || DATA_NB < 2) begin : g_bad_params
    $error("str_unpack: DATA_UP_WIDTH must be a multiple of DATA_DN_WIDTH giving at least 2 sub-words");
  end

  // Out-of-range counts (0 or above DATA_NB) mean a full word.
  function automatic logic [CNT_WIDTH-1:0] cnt_eff(input logic [CNT_WIDTH-1:0] c);
    if (c == CNT_WIDTH'(STR_CNT_FULL) || int'(c) > DATA_NB) return CNT_WIDTH'(DATA_NB);
    return c;
  endfunction

  logic [SKID_W-1:0]        skid_out;
  logic                     skid_val, skid_rdy, up_rdy_w;
  logic [DATA_UP_WIDTH-1:0] s_data;
  logic [CNT_WIDTH-1:0]     s_cnt;
  logic                     s_last;

  str_skid #(.WIDTH(SKID_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  ({bus.up_last, bus.up_cnt, bus.up_data}),
    .in_val   (bus.up_val),
    .in_rdy   (up_rdy_w),
    .out_data (skid_out),
    .out_val  (skid_val),
    .out_rdy  (skid_rdy)
  );

  assign bus.up_rdy = up_rdy_w;
  assign {s_last, s_cnt, s_data} = skid_out;

  ser_state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0]     idx_q, idx_d;
  logic                     hold_val_q, hold_val_d;
  logic [DATA_UP_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [CNT_WIDTH-1:0]     hold_cnt_q, hold_cnt_d;
  logic                     hold_last_q, hold_last_d;
  logic                     out_val_q, out_val_d;
  logic [DATA_DN_WIDTH-1:0] out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic                     advance, emit, final_sub, hold_free;
  logic [DATA_DN_WIDTH-1:0] sub_word;

  always_comb begin
    advance    = ~out_val_q | bus.dn_rdy;
    sub_word   = DATA_DN_WIDTH'(hold_data_q >> (DATA_DN_WIDTH * int'(idx_q)));
    final_sub  = (idx_q + CNT_WIDTH'(1)) == hold_cnt_q;
    state_d    = state_q;
    idx_d      = idx_q;
    out_val_d  = out_val_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    hold_free  = 1'b0;
    emit       = 1'b0;

    case (state_q)
      // Output register is always empty here, so a held word starts at once.
      ST_IDLE: emit = hold_val_q;
      ST_EMIT: begin
        if (advance) begin
          if (hold_val_q) begin
            emit = 1'b1;
          end else begin
            out_val_d  = 1'b0;
            out_last_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
    endcase

    if (emit) begin
      out_val_d  = 1'b1;
      out_data_d = sub_word;
      out_last_d = final_sub & hold_last_q;
      state_d    = ST_EMIT;
      // Freeing on the final sub-word lets the next word load on the same
      // edge, so consecutive words stream without a bubble.
      if (final_sub) begin
        hold_free = 1'b1;
        idx_d     = '0;
      end else begin
        idx_d = idx_q + CNT_WIDTH'(1);
      end
    end

    skid_rdy    = ~hold_val_q | hold_free;
    hold_val_d  = skid_rdy ? skid_val : hold_val_q;
    hold_data_d = hold_data_q;
    hold_cnt_d  = hold_cnt_q;
    hold_last_d = hold_last_q;
    if (skid_rdy && skid_val) begin
      hold_data_d = s_data;
      hold_cnt_d  = cnt_eff(s_cnt);
      hold_last_d = s_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      hold_val_q <= 1'b0;
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_val_q <= hold_val_d;
      out_val_q  <= out_val_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
    hold_cnt_q  <= hold_cnt_d;
    hold_last_q <= hold_last_d;
  end

  assign bus.dn_val  = out_val_q;
  assign bus.dn_data = out_data_q;
  assign bus.dn_last = out_last_q;

endmodule
